// File: rtl/elevator_car_controller.sv
// Motion and door controller for a single elevator car.
// Steps the car one floor at a time toward queued floors, stops and cycles
// the door, and pulses a clear request so the queue drops a served floor.
module elevator_car_controller #(
  parameter int NUM_FLOORS    = 7,
  parameter int TRAVEL_CYCLES = 16,
  parameter int DOOR_CYCLES   = 32,
  parameter int HOME_FLOOR    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] queue_status,
  input  logic                  next_up_ndown,
  input  logic                  queue_empty,
  input  logic                  door_obstruct,
  output logic [2:0]            current_floor,
  output logic                  current_up_ndown,
  output logic                  moving,
  output logic                  door_open,
  output logic                  floor_clear_valid,
  output logic [2:0]            floor_clear_idx
);

  localparam int TW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
  localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_CYCLES - 1);
  localparam logic [DW-1:0] DOOR_LAST   = DW'(DOOR_CYCLES - 1);
  localparam logic [2:0]    TOP_FLOOR   = 3'(NUM_FLOORS - 1);
  localparam logic [2:0]    HOME        = 3'(HOME_FLOOR);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE      = 2'd1,
    ARRIVE    = 2'd2,
    DOOR_OPEN = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    floor_q, floor_d;
  logic          dir_q, dir_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          moving_q, moving_d;
  logic          door_q, door_d;
  logic          clear_valid_q, clear_valid_d;
  logic [2:0]    clear_idx_q, clear_idx_d;

  // Queue widened to the full 3-bit floor index space so any floor value is a legal index
  logic [7:0] queue_pad;
  for (genvar gi = 0; gi < 8; gi++) begin : g_pad
    if (gi < NUM_FLOORS) begin : g_live
      assign queue_pad[gi] = queue_status[gi];
    end else begin : g_zero
      assign queue_pad[gi] = 1'b0;
    end
  end

  logic floor_hit;
  assign floor_hit = queue_pad[floor_q];

  // Stepping past either end of the shaft is refused
  logic at_limit;
  assign at_limit = dir_q ? (floor_q == TOP_FLOOR) : (floor_q == 3'd0);

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      floor_q       <= HOME;
      dir_q         <= 1'b1;
      tcnt_q        <= '0;
      dcnt_q        <= '0;
      moving_q      <= 1'b0;
      door_q        <= 1'b0;
      clear_valid_q <= 1'b0;
      clear_idx_q   <= 3'd0;
    end else begin
      state_q       <= state_d;
      floor_q       <= floor_d;
      dir_q         <= dir_d;
      tcnt_q        <= tcnt_d;
      dcnt_q        <= dcnt_d;
      moving_q      <= moving_d;
      door_q        <= door_d;
      clear_valid_q <= clear_valid_d;
      clear_idx_q   <= clear_idx_d;
    end
  end

  // Next state, floor, direction and counters
  always_comb begin
    state_d = state_q;
    floor_d = floor_q;
    dir_d   = dir_q;
    tcnt_d  = tcnt_q;
    dcnt_d  = dcnt_q;
    unique case (state_q)
      IDLE: begin
        if (floor_hit) begin
          state_d = DOOR_OPEN;
          dcnt_d  = '0;
        end else if (!queue_empty) begin
          dir_d   = next_up_ndown;
          state_d = MOVE;
          tcnt_d  = '0;
        end
      end
      MOVE: begin
        if (tcnt_q == TRAVEL_LAST) begin
          tcnt_d = '0;
          if (at_limit) begin
            state_d = IDLE;
          end else begin
            floor_d = dir_q ? floor_q + 3'd1 : floor_q - 3'd1;
            state_d = ARRIVE;
          end
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      ARRIVE: begin
        if (floor_hit) begin
          state_d = DOOR_OPEN;
          dcnt_d  = '0;
        end else if (queue_empty) begin
          state_d = IDLE;
        end else begin
          dir_d   = next_up_ndown;
          state_d = MOVE;
          tcnt_d  = '0;
        end
      end
      DOOR_OPEN: begin
        // While our own clear pulse is out the queue bit is still set; ignore it then
        if ((floor_hit && !clear_valid_q) || door_obstruct) begin
          dcnt_d = '0;
        end else if (dcnt_q == DOOR_LAST) begin
          dcnt_d  = '0;
          state_d = IDLE;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode, registered alongside the state
  always_comb begin
    moving_d      = (state_d == MOVE);
    door_d        = (state_d == DOOR_OPEN);
    clear_valid_d = ((state_d == DOOR_OPEN) && (state_q != DOOR_OPEN)) ||
                    ((state_q == DOOR_OPEN) && floor_hit && !clear_valid_q);
    clear_idx_d   = clear_valid_d ? floor_q : clear_idx_q;
  end

  assign current_floor     = floor_q;
  assign current_up_ndown  = dir_q;
  assign moving            = moving_q;
  assign door_open         = door_q;
  assign floor_clear_valid = clear_valid_q;
  assign floor_clear_idx   = clear_idx_q;

endmodule

// File: tb/tb_elevator_car_controller.sv
// Bench for elevator_car_controller: a small queue/resolver model drives the
// car, clear pulses are checked by a scoreboard monitor, timing by direct checks.
module tb_elevator_car_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] qs;
  logic       next_up_ndown;
  logic       queue_empty;
  logic       door_obstruct;
  logic [2:0] current_floor;
  logic       current_up_ndown;
  logic       moving;
  logic       door_open;
  logic       floor_clear_valid;
  logic [2:0] floor_clear_idx;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  logic force_res = 1'b0;
  logic prev_clear = 1'b0;

  elevator_car_controller #(
    .NUM_FLOORS(7), .TRAVEL_CYCLES(4), .DOOR_CYCLES(8), .HOME_FLOOR(0)
  ) dut (
    .clk(clk), .rst(rst), .queue_status(qs), .next_up_ndown(next_up_ndown),
    .queue_empty(queue_empty), .door_obstruct(door_obstruct),
    .current_floor(current_floor), .current_up_ndown(current_up_ndown),
    .moving(moving), .door_open(door_open),
    .floor_clear_valid(floor_clear_valid), .floor_clear_idx(floor_clear_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end else begin
      $display("ok   %s: %0d (t=%0t)", nm, act, $time);
    end
  endtask

  // Scoreboard monitor: every clear pulse must match the oldest expected floor
  always @(negedge clk) begin
    if (floor_clear_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL clear_unexpected: got idx %0d expected no pulse (t=%0t)", floor_clear_idx, $time);
      end else begin
        chk("clear_idx", int'(floor_clear_idx), exp_q.pop_front());
        chk("clear_with_door", int'(door_open), 1);
      end
      chk("clear_width", int'(prev_clear), 0);
    end
    prev_clear = floor_clear_valid;
  end

  // Direction resolver model fed from the queue and the car's registers
  task automatic upd_res();
    logic up_req, dn_req;
    if (force_res) return;
    up_req = 1'b0;
    dn_req = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (qs[i]) begin
        if (i > int'(current_floor)) up_req = 1'b1;
        if (i < int'(current_floor)) dn_req = 1'b1;
      end
    end
    queue_empty   = (qs == 7'd0);
    next_up_ndown = current_up_ndown ? (up_req || !dn_req) : (up_req && !dn_req);
  endtask

  // One clock; the queue drops a floor when it sees the clear pulse
  task automatic tick();
    @(posedge clk);
    #1;
    if (floor_clear_valid) qs[floor_clear_idx] = 1'b0;
    upd_res();
  endtask

  task automatic request(input int f);
    exp_q.push_back(f);
    qs[f] = 1'b1;
    upd_res();
  endtask

  task automatic wait_floor(input int f, input int limit);
    int n = 0;
    while (int'(current_floor) != f && n < limit) begin
      tick();
      n++;
    end
    chk($sformatf("reach_floor_%0d", f), int'(current_floor), f);
  endtask

  task automatic wait_door_close(input int exp_cycles);
    int n = 0;
    do begin
      tick();
      n++;
    end while (door_open && n < 100);
    chk("door_close_cycles", n, exp_cycles);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    qs = 7'd0;
    next_up_ndown = 1'b1;
    queue_empty = 1'b1;
    door_obstruct = 1'b0;
    #12;
    chk("rst_floor", int'(current_floor), 0);
    chk("rst_dir", int'(current_up_ndown), 1);
    chk("rst_moving", int'(moving), 0);
    chk("rst_door", int'(door_open), 0);
    chk("rst_clear", int'(floor_clear_valid), 0);
    chk("rst_idx", int'(floor_clear_idx), 0);
    rst = 1'b0;
    tick();

    // Request at the current floor while idle: door opens next cycle for 8 cycles
    request(0);
    tick();
    chk("t1_door_open", int'(door_open), 1);
    chk("t1_moving", int'(moving), 0);
    wait_door_close(8);

    // Travel 0 -> 3: 4 MOVE cycles plus 1 ARRIVE cycle per floor
    request(3);
    tick();
    chk("t2_moving_start", int'(moving), 1);
    for (int f = 1; f <= 3; f++) begin
      repeat (3) tick();
      chk("t2_moving_mid", int'(moving), 1);
      chk("t2_floor_mid", int'(current_floor), f - 1);
      tick();
      chk("t2_floor_step", int'(current_floor), f);
      chk("t2_arrive_still", int'(moving), 0);
      tick();
      if (f < 3) chk("t2_resume", int'(moving), 1);
    end
    chk("t2_door_open", int'(door_open), 1);
    wait_door_close(8);

    // Heading up to 5, reroute at floor 4 to a request at 1
    request(1);
    exp_q.delete();
    exp_q.push_back(1);
    qs[1] = 1'b0;
    qs[5] = 1'b1;
    upd_res();
    tick();
    wait_floor(4, 20);
    qs[5] = 1'b0;
    qs[1] = 1'b1;
    upd_res();
    tick();
    chk("t3_reversed_dir", int'(current_up_ndown), 0);
    chk("t3_moving", int'(moving), 1);
    wait_floor(1, 40);
    tick();
    chk("t3_door_open", int'(door_open), 1);
    wait_door_close(8);

    // Door at floor 2: re-request while open, then 20 cycles of obstruction
    request(2);
    tick();
    wait_floor(2, 20);
    tick();
    chk("t4_door_open", int'(door_open), 1);
    tick();
    tick();
    request(2);
    tick();
    door_obstruct = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!door_open) chk("t4_held_open", int'(door_open), 1);
    end
    chk("t4_held_open_end", int'(door_open), 1);
    door_obstruct = 1'b0;
    wait_door_close(8);

    // Reset asserted mid-move above floor 4
    qs[5] = 1'b1;
    upd_res();
    tick();
    wait_floor(4, 20);
    tick();
    tick();
    chk("t5_mid_move", int'(moving), 1);
    qs = 7'd0;
    upd_res();
    #2;
    rst = 1'b1;
    #1;
    chk("t5_rst_floor", int'(current_floor), 0);
    chk("t5_rst_dir", int'(current_up_ndown), 1);
    chk("t5_rst_moving", int'(moving), 0);
    chk("t5_rst_clear", int'(floor_clear_valid), 0);
    tick();
    rst = 1'b0;
    tick();

    // Top-floor guard: forced upward request at floor 6 keeps the car at 6
    request(6);
    tick();
    wait_floor(6, 60);
    tick();
    chk("t6_door_open", int'(door_open), 1);
    wait_door_close(8);
    force_res = 1'b1;
    next_up_ndown = 1'b1;
    queue_empty = 1'b0;
    tick();
    chk("t6_moving", int'(moving), 1);
    repeat (3) tick();
    chk("t6_still_moving", int'(moving), 1);
    tick();
    chk("t6_floor_held", int'(current_floor), 6);
    chk("t6_idle_moving", int'(moving), 0);
    chk("t6_idle_door", int'(door_open), 0);
    chk("t6_dir", int'(current_up_ndown), 1);
    force_res = 1'b0;
    upd_res();
    tick();
    tick();
    chk("t6_stays_idle", int'(moving), 0);

    chk("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
